// File: rtl/stw_pattern_sequencer.sv
// Multi-pattern Stop-the-World diagnosis sequencer for the BISR systolic array.
// Walks a table of operand/expected sets, launches STW per pattern and accumulates a sticky PE fault map.
module stw_pattern_sequencer #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int WORD_SIZE      = 16,
    parameter int NUM_PATTERNS   = 4,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int PE_N  = ROWS * COLS,
    localparam int PAT_W = 4 * WORD_SIZE,
    localparam int IDX_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
    localparam int CNT_W = $clog2(PE_N + 1),
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [NUM_PATTERNS*PAT_W-1:0] pattern_table,
    output logic                          STW_test_load_en,
    output logic [WORD_SIZE-1:0]          STW_mult_op1,
    output logic [WORD_SIZE-1:0]          STW_mult_op2,
    output logic [WORD_SIZE-1:0]          STW_add_op,
    output logic [WORD_SIZE-1:0]          STW_expected,
    output logic                          STW_start,
    input  logic                          STW_complete,
    input  logic [PE_N-1:0]               STW_result_mat,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout_err,
    output logic [IDX_W-1:0]              pattern_idx,
    output logic [PE_N-1:0]               fault_map,
    output logic [CNT_W-1:0]              fault_count,
    output logic [2:0]                    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FIRE  = 3'd2,
        S_WAIT  = 3'd3,
        S_ACCUM = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [TMR_W-1:0]   timer;
    logic [IDX_W-1:0]   load_idx;
    logic [PAT_W-1:0]   sel_pat;
    logic               last_pat;
    logic               timer_hit;
    logic               take_start;
    logic               take_complete;
    logic               take_timeout;
    logic               advance;

    function automatic logic [CNT_W-1:0] popcount(input logic [PE_N-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < PE_N; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    assign last_pat  = (pattern_idx == IDX_W'(NUM_PATTERNS - 1));
    assign timer_hit = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
    assign dbg_state = state;

    // Array handshake: STW_test_load_en strobes once while the operands are already valid,
    // STW_start pulses on the following cycle, and STW_complete (with STW_result_mat valid
    // in that same cycle) is honoured only while waiting; it needs no acknowledge.
    always_comb begin
        state_nx         = state;
        STW_test_load_en = 1'b0;
        STW_start        = 1'b0;
        busy             = 1'b1;
        done             = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = S_LOAD;
            end
            S_LOAD: begin
                STW_test_load_en = 1'b1;
                state_nx         = S_FIRE;
            end
            S_FIRE: begin
                STW_start = 1'b1;
                state_nx  = S_WAIT;
            end
            S_WAIT: begin
                // A complete arriving on the last timer cycle still counts.
                if (STW_complete)   state_nx = S_ACCUM;
                else if (timer_hit) state_nx = S_DONE;
            end
            S_ACCUM: begin
                state_nx = last_pat ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        if (abort && (state != S_IDLE)) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    assign take_start    = (state == S_IDLE) && start;
    assign take_complete = (state == S_WAIT) && STW_complete && !abort;
    assign take_timeout  = (state == S_WAIT) && !STW_complete && timer_hit && !abort;
    assign advance       = (state == S_ACCUM) && !last_pat && !abort;

    // Operands are captured on entry to LOAD so they are already valid during the load strobe.
    assign load_idx = take_start ? '0 : pattern_idx + IDX_W'(1);

    always_comb begin
        sel_pat = '0;
        for (int p = 0; p < NUM_PATTERNS; p++) begin
            if (load_idx == IDX_W'(p)) sel_pat = pattern_table[p*PAT_W +: PAT_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_idx  <= '0;
            timer        <= '0;
            fault_map    <= '0;
            fault_count  <= '0;
            timeout_err  <= 1'b0;
            STW_mult_op1 <= '0;
            STW_mult_op2 <= '0;
            STW_add_op   <= '0;
            STW_expected <= '0;
        end else begin
            if (take_start) begin
                pattern_idx <= '0;
                fault_map   <= '0;
                fault_count <= '0;
                timeout_err <= 1'b0;
            end else if (advance) begin
                pattern_idx <= pattern_idx + IDX_W'(1);
            end

            if (state_nx == S_LOAD) begin
                STW_mult_op1 <= sel_pat[0*WORD_SIZE +: WORD_SIZE];
                STW_mult_op2 <= sel_pat[1*WORD_SIZE +: WORD_SIZE];
                STW_add_op   <= sel_pat[2*WORD_SIZE +: WORD_SIZE];
                STW_expected <= sel_pat[3*WORD_SIZE +: WORD_SIZE];
            end

            if (state == S_FIRE)      timer <= '0;
            else if (state == S_WAIT) timer <= timer + TMR_W'(1);

            // Result bits are pass flags, so failures are the zeros.
            if (take_complete) fault_map <= fault_map | ~STW_result_mat;
            if (take_timeout)  timeout_err <= 1'b1;

            // Both paths into DONE leave fault_map untouched, so its current value is final.
            if ((state_nx == S_DONE) && (state != S_DONE)) fault_count <= popcount(fault_map);
        end
    end

endmodule

// File: tb/tb_stw_pattern_sequencer.sv
// Bench for stw_pattern_sequencer: an emulated array responder plus a run-level reference
// model that predicts run latency, load count, fault map and timeout from the pattern rules.
module tb_stw_pattern_sequencer;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int W     = 16;
    localparam int NP    = 4;
    localparam int TO    = 8;
    localparam int N     = ROWS * COLS;
    localparam int IDX_W = 2;
    localparam int CNT_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [NP*4*W-1:0] pattern_table;
    logic              STW_test_load_en;
    logic [W-1:0]      STW_mult_op1;
    logic [W-1:0]      STW_mult_op2;
    logic [W-1:0]      STW_add_op;
    logic [W-1:0]      STW_expected;
    logic              STW_start;
    logic              STW_complete;
    logic [N-1:0]      STW_result_mat;
    logic              busy;
    logic              done;
    logic              timeout_err;
    logic [IDX_W-1:0]  pattern_idx;
    logic [N-1:0]      fault_map;
    logic [CNT_W-1:0]  fault_count;
    logic [2:0]        dbg_state;

    int checks = 0;
    int passes = 0;

    // Responder configuration: per launched pattern, completion latency after STW_start
    // (0 = never completes) and the pass vector returned with the completion.
    int           resp_lat [NP];
    logic [N-1:0] resp_res [NP];
    bit           stray_en = 1'b0;

    stw_pattern_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W), .NUM_PATTERNS(NP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .pattern_table(pattern_table),
        .STW_test_load_en(STW_test_load_en),
        .STW_mult_op1(STW_mult_op1), .STW_mult_op2(STW_mult_op2),
        .STW_add_op(STW_add_op), .STW_expected(STW_expected),
        .STW_start(STW_start), .STW_complete(STW_complete),
        .STW_result_mat(STW_result_mat),
        .busy(busy), .done(done), .timeout_err(timeout_err),
        .pattern_idx(pattern_idx), .fault_map(fault_map),
        .fault_count(fault_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Array emulation: inputs change on the falling edge so they are stable at the rising edge.
    initial begin
        int launch_no;
        int cnt;
        logic [N-1:0] pend;
        launch_no = 0;
        cnt = 0;
        pend = '1;
        STW_complete = 1'b0;
        STW_result_mat = '1;
        forever begin
            @(negedge clk);
            STW_complete = 1'b0;
            STW_result_mat = N'($urandom);
            if (!busy) begin
                launch_no = 0;
                cnt = 0;
                if (stray_en) begin
                    STW_complete = 1'b1;
                    STW_result_mat = '0;
                end
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        STW_complete = 1'b1;
                        STW_result_mat = pend;
                    end
                end
                if (STW_start && launch_no < NP) begin
                    cnt = resp_lat[launch_no];
                    pend = resp_res[launch_no];
                    launch_no++;
                end
            end
        end
    end

    // Starts one run and follows it to done (or to an abort placed abort_wait WAIT cycles
    // after the launch of pattern abort_pat). poke_wait>0 re-asserts start inside pattern 0's wait.
    task automatic run_check(input string tag, input int abort_pat, input int abort_wait,
                             input int poke_wait);
        logic [N-1:0] exp_map = '0;
        bit exp_to = 1'b0;
        int exp_loads = 0;
        int exp_done = 1;
        int elapsed, n_loads, n_starts, done_at, since_fire;
        bit aborted = 1'b0;

        for (int p = 0; p < NP; p++) begin
            exp_loads++;
            if (p == abort_pat) break;
            if (resp_lat[p] == 0 || resp_lat[p] > TO) begin
                exp_to = 1'b1;
                exp_done += 2 + TO;
                break;
            end
            exp_done += 3 + resp_lat[p];
            exp_map |= ~resp_res[p];
        end

        @(negedge clk);
        start = 1'b1;
        n_loads = 0;
        n_starts = 0;
        done_at = -1;
        since_fire = -1;
        @(negedge clk);
        start = 1'b0;
        elapsed = 1;
        while (elapsed < 300) begin
            if (STW_test_load_en) begin
                check({tag, "_idx"}, 64'(pattern_idx), 64'(n_loads));
                check({tag, "_ops"}, {STW_expected, STW_add_op, STW_mult_op2, STW_mult_op1},
                      pattern_table[n_loads*4*W +: 4*W]);
                n_loads++;
            end
            if (STW_start) begin
                n_starts++;
                since_fire = 0;
            end else if (since_fire >= 0) begin
                since_fire++;
            end
            if (done) begin
                done_at = elapsed;
                break;
            end
            if (abort_pat >= 0 && n_starts == abort_pat + 1 && since_fire == abort_wait) begin
                abort = 1'b1;
                aborted = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                break;
            end
            start = (poke_wait > 0 && n_starts == 1 && since_fire == poke_wait);
            @(negedge clk);
            elapsed++;
        end
        start = 1'b0;

        if (abort_pat >= 0) begin
            check({tag, "_aborted"}, 64'(aborted), 64'(1));
            check({tag, "_abort_busy"}, 64'(busy), 64'(0));
            check({tag, "_abort_done"}, 64'(done), 64'(0));
            check({tag, "_abort_strobes"}, 64'({STW_test_load_en, STW_start}), 64'(0));
            check({tag, "_abort_loads"}, 64'(n_loads), 64'(exp_loads));
            check({tag, "_abort_map"}, 64'(fault_map), 64'(exp_map));
            check({tag, "_abort_count"}, 64'(fault_count), 64'(0));
            check({tag, "_abort_to"}, 64'(timeout_err), 64'(0));
        end else begin
            check({tag, "_done_at"}, 64'(done_at), 64'(exp_done));
            check({tag, "_loads"}, 64'(n_loads), 64'(exp_loads));
            check({tag, "_starts"}, 64'(n_starts), 64'(exp_loads));
            check({tag, "_map"}, 64'(fault_map), 64'(exp_map));
            check({tag, "_count"}, 64'(fault_count), 64'($countones(exp_map)));
            check({tag, "_timeout"}, 64'(timeout_err), 64'(exp_to));
            @(negedge clk);
            check({tag, "_post"}, 64'({done, busy}), 64'(0));
            check({tag, "_hold_exp"}, 64'(STW_expected),
                  64'(pattern_table[(exp_loads-1)*4*W + 3*W +: W]));
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic set_resp(input int p, input int lat, input logic [N-1:0] res);
        resp_lat[p] = lat;
        resp_res[p] = res;
    endtask

    task automatic random_table();
        for (int p = 0; p < NP; p++) begin
            pattern_table[p*4*W +: 4*W] = {W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
        end
    endtask

    initial begin
        logic [N-1:0] res;
        logic [N-1:0] held;
        int guard;

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        pattern_table = '0;
        for (int p = 0; p < NP; p++) set_resp(p, 3, '1);
        repeat (3) @(negedge clk);
        check("reset_strobes", 64'({STW_test_load_en, STW_start, busy, done}), 64'(0));
        check("reset_status", 64'({timeout_err, pattern_idx, fault_count}), 64'(0));
        check("reset_map", 64'(fault_map), 64'(0));
        check("reset_ops", {STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected}, 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed four-pattern run: PE(1,1) and PE(2,2) fail.
        pattern_table = {16'd30, 16'd0, 16'd6, 16'd5, 16'd2, 16'd0, 16'd1, 16'd2,
                         16'd7, 16'd1, 16'd2, 16'd3, 16'd12, 16'd0, 16'd3, 16'd4};
        set_resp(0, 3, 16'hFFFF);
        set_resp(1, 3, 16'hFFDF);
        set_resp(2, 3, 16'hFBFF);
        set_resp(3, 3, 16'hFFDF);
        run_check("four_pat", -1, 0, 0);

        // No completion at all: timeout on pattern 0.
        for (int p = 0; p < NP; p++) set_resp(p, 0, '1);
        run_check("timeout", -1, 0, 0);

        // Completion on the last timer cycle wins; clears the earlier timeout_err.
        random_table();
        set_resp(0, TO, 16'hFFFE);
        set_resp(1, 1, 16'hFFFF);
        set_resp(2, 2, 16'h7FFF);
        set_resp(3, TO, 16'hFFFF);
        run_check("edge_complete", -1, 0, 0);

        // One cycle too late on pattern 2: partial map plus timeout.
        set_resp(2, TO + 1, 16'h0000);
        run_check("late_complete", -1, 0, 0);

        // Abort during the wait of the second pattern after the first flagged PE 15.
        set_resp(0, 2, 16'h7FFF);
        set_resp(1, 0, '1);
        run_check("abort", 1, 3, 0);

        // start re-asserted while waiting must not disturb the run.
        set_resp(0, 5, 16'hEFFF);
        set_resp(1, 2, 16'hFFFF);
        set_resp(2, 4, 16'hFFF7);
        set_resp(3, 1, 16'hFFFF);
        run_check("poke_start", -1, 0, 2);

        // Completion strobes while idle are ignored.
        held = fault_map;
        stray_en = 1'b1;
        repeat (3) @(negedge clk);
        stray_en = 1'b0;
        @(negedge clk);
        check("stray_map", 64'(fault_map), 64'(held));
        check("stray_busy", 64'(busy), 64'(0));

        for (int r = 0; r < 6; r++) begin
            random_table();
            for (int p = 0; p < NP; p++) begin
                res = '1;
                if ($urandom_range(0, 1) == 1) res[$urandom_range(0, N-1)] = 1'b0;
                if ($urandom_range(0, 3) == 0) res[$urandom_range(0, N-1)] = 1'b0;
                set_resp(p, ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO), res);
            end
            run_check("random", -1, 0, 0);
        end

        // Asynchronous reset while STW_start is high for the second pattern.
        set_resp(0, 2, 16'hFFFE);
        set_resp(1, 3, 16'hFFFF);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        res = '0;
        while (guard < 100 && !(STW_start && res != '0)) begin
            if (STW_start) res = 16'h1;
            @(negedge clk);
            guard++;
        end
        check("fire_reached", 64'(STW_start), 64'(1));
        check("fire_map", 64'(fault_map), 64'(16'h0001));
        #1;
        rst_n = 1'b0;
        #1;
        check("areset_strobes", 64'({STW_test_load_en, STW_start, busy, done}), 64'(0));
        check("areset_status", 64'({timeout_err, pattern_idx, fault_count}), 64'(0));
        check("areset_map", 64'(fault_map), 64'(0));
        check("areset_ops", {STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected}, 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/stw_pattern_sequencer.md
Name: stw_pattern_sequencer

Overview:
Autonomous multi-pattern Stop-the-World (STW) diagnosis controller for the BISR systolic array. It replaces single-pattern, bench-driven STW stimulus. It steps through NUM_PATTERNS operand/expected sets, drives the array's STW load/start handshake for each, and waits for STW_complete. It ORs each per-PE fail vector into a sticky fault map, which the recompute-unit (RU) allocation logic consumes.

Parameters:
ROWS, 4, systolic array rows
COLS, 4, systolic array columns
WORD_SIZE, 16, operand width
NUM_PATTERNS, 4, number of STW patterns per run (≥1)
TIMEOUT_CYCLES, 64, maximum cycles waited for STW_complete per pattern (≥2)

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  run request; sampled only in IDLE
abort  in  1  synchronous abort of the current run
pattern_table  in  NUM_PATTERNS*4*WORD_SIZE  pattern p occupies bits [p*4*WORD_SIZE +: 4*WORD_SIZE], fields low→high {op1, op2, add_op, expected}
STW_test_load_en  out  1  operand load strobe to array
STW_mult_op1  out  WORD_SIZE  multiplier operand 1
STW_mult_op2  out  WORD_SIZE  multiplier operand 2
STW_add_op  out  WORD_SIZE  addend
STW_expected  out  WORD_SIZE  golden result
STW_start  out  1  one-cycle STW launch pulse
STW_complete  in  1  array diagnosis finished
STW_result_mat  in  ROWS*COLS  per-PE pass vector, bit r*COLS+c; 1 = pass, 0 = fault
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run (normal or timeout)
timeout_err  out  1  sticky; run ended on timeout
pattern_idx  out  clog2(NUM_PATTERNS) (min 1)  current pattern
fault_map  out  ROWS*COLS  sticky fault map, 1 = faulty PE
fault_count  out  clog2(ROWS*COLS+1)  popcount of fault_map, valid from done

Behaviour:
- Reset (rst_n=0, asynchronous): FSM→IDLE. All outputs, pattern_idx, timer, fault_map, fault_count and timeout_err are 0.
- States: IDLE, LOAD, FIRE, WAIT, ACCUM, DONE. busy=1 in all states except IDLE.
- IDLE: if start=1 → clear fault_map, fault_count and timeout_err; pattern_idx=0; next state LOAD.
- LOAD (1 cycle): STW_test_load_en=1. The operand outputs show pattern_table[pattern_idx] from this cycle onward. They are registered and stay stable through WAIT. Next state FIRE.
- FIRE (1 cycle): STW_test_load_en=0, STW_start=1. Clear the timer. Next state WAIT.
- WAIT: the timer increments each cycle.
  - STW_complete=1 → fault_map |= ~STW_result_mat, sampled the same cycle; next state ACCUM.
  - If the timer reaches TIMEOUT_CYCLES-1 with no complete → timeout_err=1; next state DONE.
  - If complete and the timeout arrive in the same cycle, complete wins.
- ACCUM (1 cycle): if pattern_idx==NUM_PATTERNS-1 → DONE; otherwise pattern_idx+1 → LOAD.
- DONE (1 cycle): done=1 and fault_count is registered as popcount(fault_map); next state IDLE.
- Per-pattern cost is 3 + w cycles, where w≥1 is the number of WAIT cycles up to and including the complete cycle. Run latency from start to done is 1 + Σ(3+w) + 1 cycles, because start is registered in IDLE.
- fault_map, fault_count, timeout_err and operands hold their values in IDLE until the next accepted start.
- STW_complete is ignored outside WAIT. start is ignored while busy.
- abort=1 in any non-IDLE state → IDLE next cycle. STW strobes deassert; done is not pulsed; fault_map keeps its partial value; fault_count is not updated. abort has priority over every transition.
- rst_n falling mid-run forces IDLE immediately, regardless of strobe state.

Test Plan:
- Reset, then start with NUM_PATTERNS=1, pattern {op1=4, op2=3, add=0, exp=12}; array returns complete 3 cycles after STW_start with result 16'hFFFF → load_en 1 cycle, start 1 cycle later, fault_map=0, fault_count=0, done exactly 8 cycles after start sampled.
- NUM_PATTERNS=4 with result vectors {FFFF, FFDF, FBFF, FFDF} (PE(1,1) and PE(2,2) fail) → fault_map=16'h0420, fault_count=2, pattern_idx sequence 0..3, four load_en/start pairs.
- STW_complete never asserted, TIMEOUT_CYCLES=8 → done 8 WAIT cycles after STW_start, timeout_err=1, fault_map=0.
- abort asserted in WAIT of pattern 2 after pattern 1 flagged bit 15 → IDLE next cycle, no done, busy=0, fault_map=16'h8000 retained.
- start pulsed during WAIT, and STW_complete pulsed in IDLE → no effect on state or fault_map. A fresh start after done clears fault_map and timeout_err.
- rst_n low during FIRE → STW_start and busy drop asynchronously; all outputs 0.
